mem_arbiter: RTL and testbench

Data-memory arbiter and stall sequencer that shares the single-port synchronous data memory between the processor core and an external loader/debug port. It sits between the Datapath memory interface (read/write strobes, address, write data) and the memory macro. It serialises accesses, converts the one-cycle memory read latency into a core stall, and arbitrates round-robin under contention.

---
 rtl/mem_arbiter.sv | 120 ++++++++++++
 tb/tb_mem_arbiter.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_arbiter
// Brief    : Shares a single-port synchronous data memory between the core and
//            a loader port; round-robin arbitration, read latency -> core stall.
// Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int AW = 8,
    parameter int DW = 16
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic [DW-1:0] core_rdata,
    output logic          core_stall,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_addr,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_gnt,
    output logic          ld_rvalid,
    output logic [DW-1:0] ld_rdata,
    output logic          mem_en,
    output logic          mem_we,
    output logic [AW-1:0] mem_addr,
    output logic [DW-1:0] mem_wdata,
    input  logic [DW-1:0] mem_rdata
);

    typedef enum logic [1:0] {
        c_IDLE      = 2'd0,
        c_CORE_RESP = 2'd1,
        c_LD_RESP   = 2'd2
    } resp_state_t;

    localparam logic c_GNT_CORE   = 1'b0;
    localparam logic c_GNT_LOADER = 1'b1;

    resp_state_t   r_resp_state;
    resp_state_t   w_resp_state_nxt;
    logic          r_last_gnt;
    logic          r_ld_rvalid;
    logic [DW-1:0] r_ld_rdata;
    logic          w_core_resp;
    logic          w_core_elig;
    logic          w_gnt_core;
    logic          w_gnt_ld;

    // The core may not reissue during its own response cycle; the loader may.
    always_comb begin
        w_core_resp = (r_resp_state == c_CORE_RESP);
        w_core_elig = core_req & ~w_core_resp;
        w_gnt_core  = w_core_elig & (~ld_req | (r_last_gnt == c_GNT_LOADER));
        w_gnt_ld    = ld_req & (~w_core_elig | (r_last_gnt == c_GNT_CORE));
    end

    always_comb begin
        w_resp_state_nxt = c_IDLE;
        mem_en           = 1'b0;
        mem_we           = 1'b0;
        mem_addr         = '0;
        mem_wdata        = '0;
        if (w_gnt_core) begin
            mem_en    = 1'b1;
            mem_we    = core_we;
            mem_addr  = core_addr;
            mem_wdata = core_wdata;
            if (!core_we) begin
                w_resp_state_nxt = c_CORE_RESP;
            end
        end else if (w_gnt_ld) begin
            mem_en    = 1'b1;
            mem_we    = ld_we;
            mem_addr  = ld_addr;
            mem_wdata = ld_wdata;
            if (!ld_we) begin
                w_resp_state_nxt = c_LD_RESP;
            end
        end
        ld_gnt     = w_gnt_ld;
        core_stall = core_req & ~(w_gnt_core & core_we) & ~w_core_resp;
        core_rdata = w_core_resp ? mem_rdata : '0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_resp_state <= c_IDLE;
            r_last_gnt   <= c_GNT_LOADER;
        end else begin
            r_resp_state <= w_resp_state_nxt;
            if (w_gnt_core) begin
                r_last_gnt <= c_GNT_CORE;
            end else if (w_gnt_ld) begin
                r_last_gnt <= c_GNT_LOADER;
            end
        end
    end

    // Loader read data is captured from the memory in its response cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ld_rvalid <= 1'b0;
            r_ld_rdata  <= '0;
        end else begin
            r_ld_rvalid <= (r_resp_state == c_LD_RESP);
            if (r_resp_state == c_LD_RESP) begin
                r_ld_rdata <= mem_rdata;
            end
        end
    end

    assign ld_rvalid = r_ld_rvalid;
    assign ld_rdata  = r_ld_rdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_arbiter
// Brief    : Self-checking bench for mem_arbiter with memory macro, transaction
//            reference model and queue-based response scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        core_req, core_we, ld_req, ld_we;
    logic [7:0]  core_addr, ld_addr, mem_addr;
    logic [15:0] core_wdata, ld_wdata, core_rdata, ld_rdata, mem_wdata;
    logic        core_stall, ld_gnt, ld_rvalid, mem_en, mem_we;
    logic [15:0] mem_rdata = '0;

    always #5 clk = ~clk;

    mem_arbiter #(.AW(8), .DW(16)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wdata(core_wdata), .core_rdata(core_rdata), .core_stall(core_stall),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
        .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid), .ld_rdata(ld_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
    );

    // Single-port synchronous memory macro.
    logic [15:0] mem_array [0:255];
    always @(posedge clk) begin
        if (mem_en) begin
            if (mem_we) mem_array[mem_addr] <= mem_wdata;
            else        mem_rdata <= mem_array[mem_addr];
        end
    end

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: whose turn it is, who is busy responding, shadow memory.
    typedef struct { int due; logic [15:0] data; } exp_t;
    exp_t        ld_q[$];
    exp_t        core_q[$];
    logic [15:0] ref_mem [0:255];
    bit          m_core_busy;
    bit          m_ld_turn;

    always @(negedge clk) begin
        bit core_ok, cw, lw;
        if (!rst_n) begin
            m_core_busy = 1'b0;
            m_ld_turn   = 1'b0;
            ld_q.delete();
            core_q.delete();
        end else begin
            core_ok = core_req && !m_core_busy;
            if (core_ok && ld_req) begin
                cw = !m_ld_turn;
                lw = m_ld_turn;
            end else begin
                cw = core_ok;
                lw = ld_req;
            end
            chk("ld_gnt", ld_gnt, lw);
            chk("mem_en", mem_en, cw || lw);
            if (cw) begin
                chk("mem_we", mem_we, core_we);
                chk("mem_addr", mem_addr, core_addr);
                if (core_we) chk("mem_wdata", mem_wdata, core_wdata);
            end else if (lw) begin
                chk("mem_we", mem_we, ld_we);
                chk("mem_addr", mem_addr, ld_addr);
                if (ld_we) chk("mem_wdata", mem_wdata, ld_wdata);
            end else begin
                chk("mem_idle", {mem_we, mem_addr, mem_wdata}, 0);
            end
            chk("core_stall", core_stall, core_req && !(cw && core_we) && !m_core_busy);
            if (!m_core_busy) chk("core_rdata_idle", core_rdata, 0);

            m_core_busy = 1'b0;
            if (cw) begin
                m_ld_turn = 1'b1;
                if (core_we) ref_mem[core_addr] = core_wdata;
                else begin
                    core_q.push_back('{due: cyc + 1, data: ref_mem[core_addr]});
                    m_core_busy = 1'b1;
                end
            end
            if (lw) begin
                m_ld_turn = 1'b0;
                if (ld_we) ref_mem[ld_addr] = ld_wdata;
                else ld_q.push_back('{due: cyc + 2, data: ref_mem[ld_addr]});
            end
        end
    end

    // Monitor: pops an expectation whenever the DUT presents a response.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (ld_rvalid) begin
                if (ld_q.size() == 0) chk("ld_rvalid_unexpected", 1, 0);
                else begin
                    e = ld_q.pop_front();
                    chk("ld_rvalid_cycle", cyc, e.due);
                    chk("ld_rdata", ld_rdata, e.data);
                end
            end else if (ld_q.size() > 0 && ld_q[0].due <= cyc) begin
                e = ld_q.pop_front();
                chk("ld_rvalid_missing", 0, 1);
            end
            if (core_req && !core_we && !core_stall) begin
                if (core_q.size() == 0) chk("core_rsp_unexpected", 1, 0);
                else begin
                    e = core_q.pop_front();
                    chk("core_rsp_cycle", cyc, e.due);
                    chk("core_rdata", core_rdata, e.data);
                end
            end else if (core_q.size() > 0 && core_q[0].due <= cyc) begin
                e = core_q.pop_front();
                chk("core_rsp_missing", 0, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_core(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        core_req = r; core_we = w; core_addr = a; core_wdata = d;
    endtask

    task automatic set_ld(input logic r, input logic w, input logic [7:0] a, input logic [15:0] d);
        ld_req = r; ld_we = w; ld_addr = a; ld_wdata = d;
    endtask

    // Protocol-following masters: each holds its request until it completes.
    task automatic run_random(input int n, input int core_pct, input int ld_pct);
        bit core_done, ld_done;
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            core_done = core_req && !core_stall;
            ld_done   = ld_req && ld_gnt;
            tick();
            if (!core_req || core_done)
                set_core($urandom_range(99) < core_pct, 1'($urandom_range(1)),
                         8'($urandom_range(15)), 16'($urandom));
            if (!ld_req || ld_done)
                set_ld($urandom_range(99) < ld_pct, 1'($urandom_range(1)),
                       8'($urandom_range(15)), 16'($urandom));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem_array[i] = '0;
            ref_mem[i]   = '0;
        end
        rst_n = 1'b0;
        set_core(0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        repeat (2) tick();
        chk("rst_mem_en", mem_en, 0);
        chk("rst_ld_gnt", ld_gnt, 0);
        chk("rst_core_rdata", core_rdata, 0);
        chk("rst_ld_rvalid", ld_rvalid, 0);
        chk("rst_ld_rdata", ld_rdata, 0);
        chk("rst_core_stall_idle", core_stall, 0);
        core_req = 1'b1;
        #1;
        chk("rst_core_stall_req", core_stall, 1);
        core_req = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();

        // Core write alone.
        set_core(1, 1, 8'h10, 16'hBEEF);
        tick();
        set_core(0, 0, 0, 0);
        chk("mem_0x10_written", mem_array[8'h10], 16'hBEEF);

        // Core read alone: stall, then response with no second issue.
        set_core(1, 0, 8'h10, 0);
        tick();
        #3;
        chk("core_read_beef", core_rdata, 16'hBEEF);
        tick();
        set_core(0, 0, 0, 0);

        // Loader preload then back-to-back reads.
        for (int i = 0; i < 4; i++) begin
            set_ld(1, 1, 8'(i), 16'(i + 1));
            tick();
        end
        for (int i = 0; i < 4; i++) begin
            set_ld(1, 0, 8'(i), 0);
            tick();
        end
        set_ld(0, 0, 0, 0);
        repeat (3) tick();

        // Contention from reset state: core wins first, then alternation.
        set_core(1, 0, 8'h20, 0);
        set_ld(1, 1, 8'h21, 16'h5A5A);
        run_random(10, 100, 100);
        set_core(0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        repeat (3) tick();

        // Reset during an outstanding loader read.
        set_ld(1, 0, 8'h02, 0);
        @(negedge clk);
        #1;
        rst_n = 1'b0;
        set_ld(0, 0, 0, 0);
        tick();
        tick();
        rst_n = 1'b1;
        #3;
        chk("post_rst_mem_en", mem_en, 0);
        chk("post_rst_ld_rvalid", ld_rvalid, 0);
        tick();
        set_core(1, 0, 8'h00, 0);
        set_ld(1, 0, 8'h01, 0);
        run_random(6, 100, 100);

        // Randomized traffic at several densities.
        run_random(300, 60, 50);
        run_random(300, 90, 90);
        run_random(200, 30, 80);

        set_core(0, 0, 0, 0);
        set_ld(0, 0, 0, 0);
        repeat (4) tick();
        chk("ld_q_drained", ld_q.size(), 0);
        chk("core_q_drained", core_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
